// File: rtl/mem_dma_pkg.sv
// Shared encodings for the memory DMA engine.
package mem_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_dma_engine.sv
// Memory bus initiator: copies LEN nibbles SRC->DST (read + write per nibble)
// or fills LEN nibbles at DST with a constant. The port is owned while busy=1.
module mem_dma_engine
  import mem_dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q;
  logic              mode_q;
  logic [ADDR_W-1:0] src_q, dst_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DATA_W-1:0] data_q;
  logic              busy_q, done_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [ADDR_W-1:0] src_d, dst_d;

  // Pointer increments; natural overflow gives the 255->0 wrap.
  always_comb begin
    src_d = src_q + 1'b1;
    dst_d = dst_q + 1'b1;
  end

  // FSM with bus outputs registered alongside the state they belong to,
  // so every output is a pure flop and resets asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_COPY;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            mode_q <= mode;
            src_q  <= src_addr;
            dst_q  <= dst_addr;
            rem_q  <= length;
            data_q <= fill_value;
            if (length == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (mode == MODE_COPY) begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
              addr_q  <= src_addr;
            end else begin
              state_q <= S_WRITE;
              busy_q  <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= dst_addr;
              wdata_q <= fill_value;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
          end else begin
            data_q  <= mem_rdata;
            src_q   <= src_d;
            state_q <= S_WRITE;
            we_q    <= 1'b1;
            addr_q  <= dst_q;
            wdata_q <= mem_rdata;
          end
        end
        S_WRITE: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
          end else begin
            dst_q <= dst_d;
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_W'(1)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              we_q    <= 1'b0;
              addr_q  <= '0;
              wdata_q <= '0;
            end else if (mode_q == MODE_COPY) begin
              state_q <= S_READ;
              we_q    <= 1'b0;
              addr_q  <= src_q;
              wdata_q <= '0;
            end else begin
              addr_q  <= dst_d;
              wdata_q <= data_q;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_dma_engine.sv
// Directed bench for mem_dma_engine paired with a 256x4 data memory model.
module tb_mem_dma_engine;
  import mem_dma_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [7:0] src_addr = '0, dst_addr = '0;
  logic [8:0] length = '0;
  logic [3:0] fill_value = '0;
  logic       busy, done, mem_we;
  logic [7:0] mem_addr;
  logic [3:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_dma_engine #(.ADDR_W(8), .DATA_W(4), .LEN_W(9)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .fill_value(fill_value), .abort(abort), .busy(busy), .done(done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Data memory model with a bench-side clear and preload port.
  logic [3:0] mem [256];
  logic       clr = 1'b1, pl_we = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [3:0] pl_data = '0;

  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
    else if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [3:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  // Presents a request for one edge; returns just after the sampling edge.
  task automatic kick(input logic m, input logic [7:0] s, input logic [7:0] d,
                      input logic [8:0] n, input logic [3:0] v);
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = v;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after the sampling edge until done is seen (bounded).
  task automatic wait_done(output int cyc, output int bsy, output int wes);
    cyc = 0; bsy = 0; wes = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) bsy++;
      if (mem_we === 1'b1) wes++;
      tick();
      cyc++;
    end
  endtask

  logic [3:0] pat [4];
  int cyc, bsy, wes, dn;
  logic [7:0] a;

  initial begin
    pat[0] = 4'h3; pat[1] = 4'hA; pat[2] = 4'h5; pat[3] = 4'hF;

    // Reset state
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    clr = 1'b0;
    rst = 1'b0;
    tick();

    // 1: COPY 0x10 -> 0x80, len 4
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), pat[i]);
    kick(MODE_COPY, 8'h10, 8'h80, 9'd4, 4'h0);
    check("t1_busy_first", busy, 1);
    check("t1_addr_first", mem_addr, 8'h10);
    wait_done(cyc, bsy, wes);
    check("t1_latency", cyc, 8);
    check("t1_busy_cycles", bsy, 8);
    check("t1_writes", wes, 4);
    check("t1_busy_at_done", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);
    for (int i = 0; i < 4; i++) begin
      a = 8'h80 + 8'(i);
      check("t1_mem", mem[a], pat[i]);
    end

    // 2: FILL wrapping 0xFE..0x01 with 9
    poke(8'h02, 4'h5);
    kick(MODE_FILL, 8'h00, 8'hFE, 9'd4, 4'h9);
    check("t2_we_first", mem_we, 1);
    check("t2_wdata_first", mem_wdata, 4'h9);
    wait_done(cyc, bsy, wes);
    check("t2_latency", cyc, 4);
    check("t2_mem_fe", mem[8'hFE], 4'h9);
    check("t2_mem_ff", mem[8'hFF], 4'h9);
    check("t2_mem_00", mem[8'h00], 4'h9);
    check("t2_mem_01", mem[8'h01], 4'h9);
    check("t2_mem_02", mem[8'h02], 4'h5);
    tick();

    // 3: zero-length COPY; done appears right after the sampling edge
    kick(MODE_COPY, 8'h10, 8'h50, 9'd0, 4'h0);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_we", mem_we, 0);
    tick();
    check("t3_done_pulse", done, 0);
    check("t3_busy_after", busy, 0);
    check("t3_mem_50", mem[8'h50], 4'h0);

    // 4: second start mid COPY is ignored
    poke(8'h40, 4'hC);
    kick(MODE_COPY, 8'h10, 8'h90, 9'd4, 4'h0);
    tick(); tick();
    mode = MODE_FILL; dst_addr = 8'h40; length = 9'd1; fill_value = 4'h6;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bsy, wes);
    check("t4_latency", cyc + 3, 8);
    check("t4_mem_40", mem[8'h40], 4'hC);
    for (int i = 0; i < 4; i++) begin
      a = 8'h90 + 8'(i);
      check("t4_mem", mem[a], pat[i]);
    end
    tick();

    // 5: abort in the second WRITE of a FILL
    for (int i = 0; i < 8; i++) poke(8'h20 + 8'(i), 4'h1);
    kick(MODE_FILL, 8'h00, 8'h20, 9'd8, 4'h7);
    tick();
    check("t5_we_w2", mem_we, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_we", mem_we, 0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) dn++;
      tick();
    end
    check("t5_no_done", dn, 0);
    check("t5_mem_20", mem[8'h20], 4'h7);
    check("t5_mem_21", mem[8'h21], 4'h7);
    for (int i = 2; i < 8; i++) begin
      a = 8'h20 + 8'(i);
      check("t5_untouched", mem[a], 4'h1);
    end

    // 6: asynchronous reset mid COPY, then a clean COPY
    kick(MODE_COPY, 8'h10, 8'hB0, 9'd4, 4'h0);
    tick(); tick();
    check("t6_busy_pre", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_busy", busy, 0);
    check("t6_addr", mem_addr, 0);
    check("t6_we", mem_we, 0);
    check("t6_wdata", mem_wdata, 0);
    check("t6_done", done, 0);
    #1 rst = 1'b0;
    tick();
    check("t6_partial_b0", mem[8'hB0], 4'h3);
    check("t6_partial_b1", mem[8'hB1], 4'h0);
    kick(MODE_COPY, 8'h10, 8'hC0, 9'd4, 4'h0);
    wait_done(cyc, bsy, wes);
    check("t6_latency", cyc, 8);
    for (int i = 0; i < 4; i++) begin
      a = 8'hC0 + 8'(i);
      check("t6_mem", mem[a], pat[i]);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
